uart_tx_fifo: RTL and testbench

Transmit-side byte buffer sitting directly upstream of the flexible-baud UART transmitter. It accepts bytes from the CPU/bus side with a single-cycle write strobe, holds up to 2^DEPTH_LOG2 bytes, and drains them in order into the transmitter's `tx_data` / `tx_data_valid` / `tx_data_ready` handshake. It also reports fill status and a sticky overflow flag for the UART status register.

---
 rtl/uart_tx_fifo.sv | 76 +++++++
 tb/tb_uart_tx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding the UART transmitter: show-ahead head byte,
// fill status, and a sticky overflow flag for the status register.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_data_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Handshake: a byte transfers in every cycle tx_data_valid is high. Valid is
  // gated by ready because the transmitter latches whenever idle and sees
  // valid, so valid must never be asserted while ready is low.
  assign tx_data_valid = !empty && tx_data_ready && !flush;
  assign tx_data       = mem[rd_ptr];

  assign pop  = tx_data_valid;
  assign push = wr_en && !full && !flush;
  // A full FIFO drops the write even if a pop frees a slot this cycle.
  assign drop = wr_en && full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear; flush leaves the flag alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: hand-written vector table, corner sequences, and a
// randomized run checked against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: byte queue plus sticky flag.
  logic [7:0] exp_q[$];
  logic       m_ovf;

  // Samples captured mid-cycle by do_cycle.
  logic [4:0] a_count;
  logic       a_valid, a_full, a_empty, a_ovf;
  logic [7:0] a_data;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ready;
    logic       flush;
    logic       clr;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add_vec(logic w, logic [7:0] d, logic r, logic f, logic c,
                                  logic [4:0] ec, logic ev, logic [7:0] ed, logic eo);
    vec_t v;
    v.wr_en = w; v.wr_data = d; v.ready = r; v.flush = f; v.clr = c;
    v.e_count = ec; v.e_valid = ev; v.e_data = ed; v.e_ovf = eo;
    vecs.push_back(v);
  endfunction

  // One clock cycle: drive, sample at negedge, check against the model,
  // advance the model by the FIFO rules, then cross the rising edge.
  task automatic do_cycle(input logic w, input logic [7:0] d, input logic r,
                          input logic f, input logic c);
    logic m_valid;
    logic was_full;
    wr_en = w; wr_data = d; tx_data_ready = r; flush = f; clr_overflow = c;
    @(negedge clk);
    a_count = count; a_valid = tx_data_valid; a_data = tx_data;
    a_full = full; a_empty = empty; a_ovf = overflow;
    m_valid = (exp_q.size() != 0) && r && !f;
    chk("model_valid", a_valid, m_valid);
    chk("model_count", a_count, exp_q.size());
    chk("model_full", a_full, exp_q.size() == DEPTH);
    chk("model_empty", a_empty, exp_q.size() == 0);
    chk("model_ovf", a_ovf, m_ovf);
    if (m_valid) chk("model_data", a_data, exp_q[0]);
    was_full = (exp_q.size() == DEPTH);
    if (f) begin
      exp_q.delete();
      if (c) m_ovf = 1'b0;
    end else begin
      if (m_valid) void'(exp_q.pop_front());
      if (w && !was_full) exp_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    do_cycle(1'b0, 8'h00, r, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_data = '0; wr_en = 1'b0;
    clr_overflow = 1'b0; tx_data_ready = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_valid", tx_data_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte write and offer.
    add_vec(1, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0);
    add_vec(0, 8'h00, 1, 0, 0, 1, 1, 8'hA5, 0);
    add_vec(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
    // Fill with ready low, then a dropped 17th write.
    for (int i = 0; i < 16; i++) add_vec(1, 8'(i), 0, 0, 0, 5'(i), 0, 8'h00, 0);
    add_vec(1, 8'h55, 0, 0, 0, 16, 0, 8'h00, 0);
    add_vec(0, 8'h00, 0, 0, 0, 16, 0, 8'h00, 1);
    // Drain in order.
    for (int i = 0; i < 16; i++) add_vec(0, 8'h00, 1, 0, 0, 5'(16 - i), 1, 8'(i), 1);
    add_vec(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 1);
    add_vec(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1);
    add_vec(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    // Eight queued, push and pop together keeps count; then flush.
    for (int i = 0; i < 8; i++) add_vec(1, 8'(8'h80 + i), 0, 0, 0, 5'(i), 0, 8'h00, 0);
    add_vec(1, 8'hC0, 1, 0, 0, 8, 1, 8'h80, 0);
    add_vec(0, 8'h00, 0, 0, 0, 8, 0, 8'h00, 0);
    add_vec(0, 8'h00, 1, 1, 0, 8, 0, 8'h00, 0);
    add_vec(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      do_cycle(vecs[k].wr_en, vecs[k].wr_data, vecs[k].ready, vecs[k].flush, vecs[k].clr);
      chk("vec_count", a_count, vecs[k].e_count);
      chk("vec_valid", a_valid, vecs[k].e_valid);
      chk("vec_empty", a_empty, vecs[k].e_count == 0);
      chk("vec_full", a_full, vecs[k].e_count == 16);
      chk("vec_ovf", a_ovf, vecs[k].e_ovf);
      if (vecs[k].e_valid) chk("vec_data", a_data, vecs[k].e_data);
    end

    // Flush with five queued and a simultaneous write; overflow survives.
    for (int i = 0; i < 17; i++) do_cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) idle(1'b1);
    idle(1'b0);
    chk("pre_flush_count", a_count, 5);
    do_cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    chk("flush_gates_valid", a_valid, 0);
    idle(1'b0);
    chk("post_flush_count", a_count, 0);
    chk("post_flush_empty", a_empty, 1);
    chk("post_flush_ovf", a_ovf, 1);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("clr_ovf", a_ovf, 0);
    // Set and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("set_beats_clr", a_ovf, 1);
    chk("full_held", a_count, 16);

    // Asynchronous reset between edges.
    #1 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_ovf", overflow, 0);
    chk("async_rst_empty", empty, 1);
    #1 rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;

    // Randomized run in phases of varying ready probability.
    for (int p = 0; p < 12; p++) begin
      int rdy_pct;
      rdy_pct = (p % 3 == 0) ? 5 : ((p % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 60; i++) begin
        do_cycle($urandom_range(99) < 60,
                 8'($urandom_range(255)),
                 $urandom_range(99) < rdy_pct,
                 $urandom_range(99) < 2,
                 $urandom_range(99) < 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
